// File: rtl/acq_sequencer_if.sv
// acq_sequencer_if
// Handshake bundle between the acquisition sequencer, the UART block and the
// capture datapath.
//   rx_ready / rx_data     : received command byte, one-cycle valid pulse
//   sample_valid           : datapath has a fresh 4-channel sample
//   tx_ready               : UART transmitter idle
//   hold_data_sel          : latch current sample into hold registers (pulse)
//   byte_to_send_sel       : held byte routed to UART TX data input
//   tx_send                : start a UART transmission (pulse)
// master = sequencer side, slave = UART/datapath side.
interface acq_sequencer_if;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       sample_valid;
  logic       tx_ready;
  logic       hold_data_sel;
  logic [2:0] byte_to_send_sel;
  logic       tx_send;

  modport master (
    input  rx_ready, rx_data, sample_valid, tx_ready,
    output hold_data_sel, byte_to_send_sel, tx_send
  );

  modport slave (
    output rx_ready, rx_data, sample_valid, tx_ready,
    input  hold_data_sel, byte_to_send_sel, tx_send
  );
endinterface

// File: rtl/acq_sequencer.sv
// acq_sequencer
// Decodes single-byte UART commands, latches one 4-channel sample set into the
// datapath hold registers and streams the held frame out byte by byte through
// the UART transmitter, single-shot or continuous.
// Ports:
//   clk, reset_b      : system clock, async active-low reset
//   bus (master)      : UART rx/tx handshake and datapath hold/select
//   data_logging      : high while a capture session is active (state != IDLE)
//   frame_count       : frames fully transmitted since reset (wraps)
//   state_debug       : current state encoding
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for 'S' or 'C'
// ARM       | waiting for a sample; 'X' aborts back to IDLE
// HOLD      | latch sample (pulse shows one cycle later), reset byte index
// SEND      | wait for UART idle, then fire tx_send for current byte
// WAIT_LOW  | wait for UART to go busy (byte accepted)
// WAIT_HIGH | wait for UART to go idle again (byte done)
// NEXT      | advance byte index or close the frame
module acq_sequencer #(
  parameter logic [7:0] CMD_SINGLE = 8'h53,
  parameter logic [7:0] CMD_CONT   = 8'h43,
  parameter logic [7:0] CMD_STOP   = 8'h58,
  parameter int         NUM_BYTES  = 8
) (
  input  logic                clk,
  input  logic                reset_b,
  acq_sequencer_if.master     bus,
  output logic                data_logging,
  output logic [15:0]         frame_count,
  output logic [2:0]          state_debug
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    HOLD      = 3'd2,
    SEND      = 3'd3,
    WAIT_LOW  = 3'd4,
    WAIT_HIGH = 3'd5,
    NEXT      = 3'd6,
    RSVD      = 3'd7
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(NUM_BYTES - 1);

  state_t      state_q, state_d;
  logic        cont_q, cont_d;
  logic        stop_q, stop_d;
  logic [2:0]  idx_q, idx_d;
  logic        hold_q, hold_d;
  logic [2:0]  sel_q, sel_d;
  logic        send_q, send_d;
  logic        logging_q, logging_d;
  logic [15:0] frame_count_q, frame_count_d;

  logic cmd_single, cmd_cont, cmd_stop;

  assign cmd_single = bus.rx_ready && (bus.rx_data == CMD_SINGLE);
  assign cmd_cont   = bus.rx_ready && (bus.rx_data == CMD_CONT);
  assign cmd_stop   = bus.rx_ready && (bus.rx_data == CMD_STOP);

  always_comb begin
    state_d       = state_q;
    cont_d        = cont_q;
    stop_d        = stop_q;
    idx_d         = idx_q;
    sel_d         = sel_q;
    frame_count_d = frame_count_q;
    send_d        = 1'b0;
    // The latch pulse trails the HOLD state by one cycle so it lands two
    // cycles after sample_valid.
    hold_d        = (state_q == HOLD);

    // A stop during a frame only marks the session; the frame still finishes.
    if (cmd_stop && (state_q inside {HOLD, SEND, WAIT_LOW, WAIT_HIGH, NEXT}))
      stop_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (cmd_single) begin
          state_d = ARM;
          cont_d  = 1'b0;
        end else if (cmd_cont) begin
          state_d = ARM;
          cont_d  = 1'b1;
        end
      end
      ARM: begin
        if (cmd_stop) begin
          state_d = IDLE;
          cont_d  = 1'b0;
          stop_d  = 1'b0;
        end else if (bus.sample_valid) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        idx_d   = 3'd0;
        state_d = SEND;
      end
      SEND: begin
        if (bus.tx_ready) begin
          send_d  = 1'b1;
          sel_d   = idx_q;
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!bus.tx_ready) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (bus.tx_ready) state_d = NEXT;
      end
      NEXT: begin
        if (idx_q < LAST_IDX) begin
          idx_d   = idx_q + 3'd1;
          state_d = SEND;
        end else begin
          frame_count_d = frame_count_q + 16'd1;
          // stop_d already includes a stop arriving on this very cycle.
          if (cont_q && !stop_d) begin
            state_d = ARM;
          end else begin
            state_d = IDLE;
            cont_d  = 1'b0;
            stop_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cont_d  = 1'b0;
        stop_d  = 1'b0;
        idx_d   = 3'd0;
      end
    endcase

    logging_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q       <= IDLE;
      cont_q        <= 1'b0;
      stop_q        <= 1'b0;
      idx_q         <= 3'd0;
      hold_q        <= 1'b0;
      sel_q         <= 3'd0;
      send_q        <= 1'b0;
      logging_q     <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      cont_q        <= cont_d;
      stop_q        <= stop_d;
      idx_q         <= idx_d;
      hold_q        <= hold_d;
      sel_q         <= sel_d;
      send_q        <= send_d;
      logging_q     <= logging_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign bus.hold_data_sel    = hold_q;
  assign bus.byte_to_send_sel = sel_q;
  assign bus.tx_send          = send_q;
  assign data_logging         = logging_q;
  assign frame_count          = frame_count_q;
  assign state_debug          = state_q;

endmodule

// File: tb/tb_acq_sequencer.sv
module tb_acq_sequencer;
  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        data_logging;
  logic [15:0] frame_count;
  logic [2:0]  state_debug;

  acq_sequencer_if bus();

  acq_sequencer #(.NUM_BYTES(8)) dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .bus          (bus),
    .data_logging (data_logging),
    .frame_count  (frame_count),
    .state_debug  (state_debug)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Session-level view: a session is opened by S/C, each frame is
  // "wait sample -> latch -> for each byte: wait idle, send, busy, idle -> close".
  localparam int P_IDLE = 0, P_ARM = 1, P_HOLD = 2, P_SEND = 3, P_BUSY = 4, P_DONE = 5, P_NEXT = 6;
  int          m_phase;
  int          m_bytes_sent;
  bit          m_repeat, m_end_req;
  bit          e_hold, e_send, e_log;
  logic [2:0]  e_sel;
  logic [15:0] e_fc;
  bit          c_s, c_c, c_x;
  int          m_new;

  always @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      m_phase = P_IDLE; m_bytes_sent = 0; m_repeat = 0; m_end_req = 0;
      e_hold = 0; e_send = 0; e_log = 0; e_sel = 0; e_fc = 0;
    end else begin
      c_s = bus.rx_ready && bus.rx_data == 8'h53;
      c_c = bus.rx_ready && bus.rx_data == 8'h43;
      c_x = bus.rx_ready && bus.rx_data == 8'h58;
      e_hold = (m_phase == P_HOLD);
      e_send = 0;
      m_new = m_phase;
      if (c_x && m_phase >= P_HOLD) m_end_req = 1;
      if (m_phase == P_IDLE && (c_s || c_c)) begin
        m_new = P_ARM; m_repeat = c_c;
      end else if (m_phase == P_ARM && c_x) begin
        m_new = P_IDLE; m_repeat = 0; m_end_req = 0;
      end else if (m_phase == P_ARM && bus.sample_valid) begin
        m_new = P_HOLD;
      end else if (m_phase == P_HOLD) begin
        m_bytes_sent = 0; m_new = P_SEND;
      end else if (m_phase == P_SEND && bus.tx_ready) begin
        e_send = 1; e_sel = 3'(m_bytes_sent); m_new = P_BUSY;
      end else if (m_phase == P_BUSY && !bus.tx_ready) begin
        m_new = P_DONE;
      end else if (m_phase == P_DONE && bus.tx_ready) begin
        m_new = P_NEXT;
      end else if (m_phase == P_NEXT) begin
        m_bytes_sent++;
        if (m_bytes_sent < 8) m_new = P_SEND;
        else begin
          e_fc = e_fc + 16'd1;
          if (m_repeat && !m_end_req) m_new = P_ARM;
          else begin m_new = P_IDLE; m_repeat = 0; m_end_req = 0; end
        end
      end
      m_phase = m_new;
      e_log = (m_phase != P_IDLE);
    end
  end

  always @(negedge clk) begin
    if (reset_b)
      check("cycle_outputs",
            {bus.hold_data_sel, bus.byte_to_send_sel, bus.tx_send, data_logging, frame_count, state_debug},
            {e_hold, e_sel, e_send, e_log, e_fc, 3'(m_phase)});
  end

  // ---------------- monitor ----------------
  int         hold_cnt = 0;
  logic [2:0] sel_log[$];
  always @(negedge clk) begin
    if (reset_b) begin
      if (bus.hold_data_sel) hold_cnt++;
      if (bus.tx_send) sel_log.push_back(bus.byte_to_send_sel);
    end
  end

  // ---------------- UART transmitter model ----------------
  bit uart_force_busy = 0;
  initial begin
    automatic bit pend = 0;
    automatic int busy = 0;
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (uart_force_busy) begin
        bus.tx_ready = 1'b0; busy = 0; pend = 0;
      end else if (pend) begin
        pend = 0; bus.tx_ready = 1'b0; busy = 20;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) bus.tx_ready = 1'b1;
      end else begin
        bus.tx_ready = 1'b1;
      end
      if (bus.tx_send) pend = 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_rx(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_ready = 1'b1; bus.rx_data = b;
    @(posedge clk); #1;
    bus.rx_ready = 1'b0; bus.rx_data = 8'h00;
  endtask

  task automatic pulse_sv();
    @(posedge clk); #1;
    bus.sample_valid = 1'b1;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset_b = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_b = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string name);
    int n;
    n = 0;
    while (state_debug !== st && n < budget) begin
      @(negedge clk); n++;
    end
    check(name, state_debug, st);
  endtask

  task automatic wait_sel(input logic [2:0] st, input logic [2:0] sel, input int budget, input string name);
    int n;
    n = 0;
    while (!(state_debug === st && bus.byte_to_send_sel === sel) && n < budget) begin
      @(negedge clk); n++;
    end
    check(name, {state_debug, bus.byte_to_send_sel}, {st, sel});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hb, sb;
    bus.rx_ready = 1'b0; bus.rx_data = 8'h00; bus.sample_valid = 1'b0;
    #22 reset_b = 1'b1;
    @(negedge clk);
    check("reset_outputs",
          {bus.hold_data_sel, bus.byte_to_send_sel, bus.tx_send, data_logging, frame_count, state_debug}, 32'd0);

    // ---- single frame ----
    hb = hold_cnt; sb = sel_log.size();
    send_rx(8'h53);
    check("cmd_to_arm", {state_debug, data_logging}, {3'd1, 1'b1});
    pulse_sv();
    check("hold_state_no_pulse_yet", {state_debug, bus.hold_data_sel}, {3'd2, 1'b0});
    @(posedge clk); #1;
    check("hold_pulse", {state_debug, bus.hold_data_sel}, {3'd3, 1'b1});
    @(posedge clk); #1;
    check("first_tx_send", {state_debug, bus.tx_send, bus.byte_to_send_sel}, {3'd4, 1'b1, 3'd0});
    wait_state(3'd0, 2000, "single_to_idle");
    check("single_hold_cnt", hold_cnt - hb, 1);
    check("single_send_cnt", sel_log.size() - sb, 8);
    for (int i = 0; i < 8; i++) check("single_sel_order", sel_log[sb + i], 32'(i));
    check("single_frame_count", frame_count, 16'd1);
    check("single_logging", data_logging, 1'b0);

    // ---- continuous, stop during frame 3 ----
    do_reset();
    hb = hold_cnt; sb = sel_log.size();
    send_rx(8'h43);
    pulse_sv();
    repeat (3) @(negedge clk);
    pulse_sv();
    wait_state(3'd1, 2000, "cont_frame1_rearm");
    pulse_sv();
    wait_state(3'd1, 2000, "cont_frame2_rearm");
    pulse_sv();
    wait_sel(3'd5, 3'd4, 2000, "cont_reach_byte4_wait_high");
    send_rx(8'h58);
    wait_state(3'd0, 2000, "cont_to_idle");
    check("cont_hold_cnt", hold_cnt - hb, 3);
    check("cont_send_cnt", sel_log.size() - sb, 24);
    for (int i = 0; i < 24; i++) check("cont_sel_order", sel_log[sb + i], 32'(i % 8));
    check("cont_frame_count", frame_count, 16'd3);

    // ---- stop while armed ----
    hb = hold_cnt;
    send_rx(8'h53);
    @(negedge clk);
    check("arm_before_stop", state_debug, 3'd1);
    send_rx(8'h58);
    check("stop_in_arm_idle", {state_debug, data_logging}, {3'd0, 1'b0});
    repeat (3) @(negedge clk);
    check("stop_in_arm_no_hold", hold_cnt - hb, 0);
    check("stop_in_arm_fc", frame_count, 16'd3);

    // ---- junk in idle ----
    do_reset();
    send_rx(8'h41);
    pulse_sv();
    send_rx(8'h58);
    pulse_sv();
    repeat (4) @(negedge clk);
    check("idle_ignores_junk",
          {bus.hold_data_sel, bus.byte_to_send_sel, bus.tx_send, data_logging, frame_count, state_debug}, 32'd0);

    // ---- tx_ready held low in SEND ----
    do_reset();
    uart_force_busy = 1;
    sb = sel_log.size();
    send_rx(8'h53);
    pulse_sv();
    repeat (100) @(negedge clk);
    check("busy_no_send", sel_log.size() - sb, 0);
    check("busy_stays_send", state_debug, 3'd3);
    uart_force_busy = 0;
    wait_state(3'd0, 2000, "busy_release_to_idle");
    check("busy_release_sends", sel_log.size() - sb, 8);
    check("busy_frame_count", frame_count, 16'd1);

    // ---- async reset mid-frame ----
    do_reset();
    send_rx(8'h53);
    pulse_sv();
    wait_sel(3'd4, 3'd5, 2000, "reach_byte5_wait_low");
    #2 reset_b = 1'b0;
    #1;
    check("async_reset_outputs",
          {bus.hold_data_sel, bus.byte_to_send_sel, bus.tx_send, data_logging, state_debug}, 32'd0);
    check("async_reset_fc", frame_count, 16'd0);
    repeat (2) @(posedge clk);
    #2 reset_b = 1'b1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
